// File: rtl/rv_pkg.sv
// Shared RV32 front-end definitions: opcode constants, field slicers and fetch defaults.
// Used by the fetch unit to split the head instruction word for decode.
package rv_pkg;

  localparam int unsigned XLEN_DEF     = 32;
  localparam logic [31:0] RESET_PC_DEF = 32'h0000_0000;

  localparam logic [6:0] OP_R      = 7'h33;
  localparam logic [6:0] OP_I      = 7'h13;
  localparam logic [6:0] OP_LOAD   = 7'h03;
  localparam logic [6:0] OP_STORE  = 7'h23;
  localparam logic [6:0] OP_BRANCH = 7'h63;
  localparam logic [6:0] OP_JAL    = 7'h6F;

  function automatic logic [6:0] op_of(input logic [31:0] i);
    return i[6:0];
  endfunction

  function automatic logic [2:0] funct3_of(input logic [31:0] i);
    return i[14:12];
  endfunction

  function automatic logic [6:0] funct7_of(input logic [31:0] i);
    return i[31:25];
  endfunction

endpackage

// File: rtl/instr_fifo.sv
// DEPTH-entry synchronous FIFO with flush and occupancy count; read data is the head, combinational.
// Push into a full FIFO is accepted only with a same-cycle pop; flush wins over push and pop.
module instr_fifo #(
  parameter int unsigned W     = 32,
  parameter int unsigned DEPTH = 2
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       flush,
  input  logic                       push,
  input  logic [W-1:0]               din,
  input  logic                       pop,
  output logic [W-1:0]               dout,
  output logic [$clog2(DEPTH):0]     count
);
  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic          full, empty, do_push, do_pop;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign do_pop  = pop & ~empty & ~flush;
  assign do_push = push & ~flush & (~full | do_pop);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end

  // Storage needs no reset: the head is only meaningful while count is non-zero.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

  assign dout = mem[rd_ptr];

  a_no_overflow: assert property (@(posedge clk) disable iff (!rst)
    !(push && !flush && full && !do_pop));
  a_no_underflow: assert property (@(posedge clk) disable iff (!rst)
    !(pop && !flush && empty));

endmodule

// File: rtl/instr_fetch_unit.sv
// Instruction fetch: credit-limited imem requests, in-order responses buffered for decode; rsp->instr 1 cycle.
// Decode stalls via instr_ready; requests stop once in-flight + buffered reaches DEPTH; PCSrc flushes and redirects.
module instr_fetch_unit
  import rv_pkg::*;
#(
  parameter int unsigned     XLEN     = XLEN_DEF,
  parameter logic [XLEN-1:0] RESET_PC = XLEN'(RESET_PC_DEF),
  parameter int unsigned     DEPTH    = 2
) (
  input  logic            clk,
  input  logic            rst,
  output logic            imem_req_valid,
  input  logic            imem_req_ready,
  output logic [XLEN-1:0] imem_req_addr,
  input  logic            imem_rsp_valid,
  input  logic [31:0]     imem_rsp_data,
  output logic            instr_valid,
  input  logic            instr_ready,
  output logic [31:0]     instr,
  output logic [XLEN-1:0] instr_pc,
  output logic [6:0]      Op,
  output logic [2:0]      funct3,
  output logic [6:0]      funct7,
  input  logic            PCSrc,
  input  logic [XLEN-1:0] PCTarget
);
  localparam int unsigned CW = $clog2(DEPTH) + 1;
  localparam int unsigned EW = XLEN + 32;

  logic [XLEN-1:0] fetch_pc, inflight_pc;
  logic [CW-1:0]   outstanding, drop_cnt, buf_count, pcq_count;
  logic [CW:0]     used;
  logic [EW-1:0]   head;
  logic            req_fire, buf_push, buf_pop;
  logic            unused_ok;

  assign buf_pop = instr_valid & instr_ready;

  // A head consumed this cycle frees its slot, which keeps a 1-cycle imem streaming at DEPTH=2.
  assign used = {1'b0, outstanding} + {1'b0, buf_count} - {{CW{1'b0}}, buf_pop};

  assign imem_req_valid = rst & ~PCSrc & (used < (CW+1)'(DEPTH));
  assign imem_req_addr  = fetch_pc;
  assign req_fire       = imem_req_valid & imem_req_ready;
  assign buf_push       = imem_rsp_valid & (drop_cnt == '0);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      fetch_pc    <= RESET_PC;
      outstanding <= '0;
      drop_cnt    <= '0;
    end else begin
      outstanding <= outstanding + CW'(req_fire) - CW'(imem_rsp_valid);
      if (PCSrc) begin
        fetch_pc <= {PCTarget[XLEN-1:2], 2'b00};
        // Everything still in flight after this cycle belongs to the old stream.
        drop_cnt <= outstanding - CW'(imem_rsp_valid);
      end else begin
        if (req_fire) fetch_pc <= fetch_pc + XLEN'(4);
        if (imem_rsp_valid && drop_cnt != '0) drop_cnt <= drop_cnt - CW'(1);
      end
    end
  end

  instr_fifo #(.W(EW), .DEPTH(DEPTH)) u_buf (
    .clk   (clk),
    .rst   (rst),
    .flush (PCSrc),
    .push  (buf_push),
    .din   ({inflight_pc, imem_rsp_data}),
    .pop   (buf_pop),
    .dout  (head),
    .count (buf_count)
  );

  // In-flight PCs are never flushed: each still pairs with a response that will arrive.
  instr_fifo #(.W(XLEN), .DEPTH(DEPTH)) u_pcq (
    .clk   (clk),
    .rst   (rst),
    .flush (1'b0),
    .push  (req_fire),
    .din   (fetch_pc),
    .pop   (imem_rsp_valid),
    .dout  (inflight_pc),
    .count (pcq_count)
  );

  assign instr_valid = (buf_count != '0);
  assign instr       = instr_valid ? head[31:0]    : '0;
  assign instr_pc    = instr_valid ? head[EW-1:32] : '0;
  assign Op          = op_of(instr);
  assign funct3      = funct3_of(instr);
  assign funct7      = funct7_of(instr);

  assign unused_ok = ^{PCTarget[1:0], pcq_count};

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Randomized bench: imem model with in-order 1-3 cycle responses, scoreboard of the expected program stream.
module tb_instr_fetch_unit;
  localparam int DEPTH = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic        imem_req_valid, imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        instr_valid, instr_ready;
  logic [31:0] instr, instr_pc;
  logic [6:0]  Op, funct7;
  logic [2:0]  funct3;
  logic        PCSrc;
  logic [31:0] PCTarget;

  always #5 clk = ~clk;

  instr_fetch_unit #(.XLEN(32), .RESET_PC(32'h0), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst),
    .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready), .imem_req_addr(imem_req_addr),
    .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
    .instr_valid(instr_valid), .instr_ready(instr_ready), .instr(instr), .instr_pc(instr_pc),
    .Op(Op), .funct3(funct3), .funct7(funct7),
    .PCSrc(PCSrc), .PCTarget(PCTarget)
  );

  typedef struct { logic [31:0] addr; int due; } req_t;
  req_t        imem_q[$];
  logic [31:0] exp_q[$];
  logic [31:0] exp_tail, exp_fetch;
  int          cyc = 0, last_due = 0, checks = 0, passed = 0;
  int          lat_min = 1, lat_max = 1;
  bit          prev_redirect = 1'b0;

  // Program memory contents: a fixed function of the address, with one known R-type word.
  function automatic logic [31:0] word_of(input logic [31:0] a);
    if (a == 32'h40) return 32'h00B5_0533;
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
  endtask

  task automatic restart_stream(input logic [31:0] t);
    exp_q.delete();
    exp_tail  = {t[31:2], 2'b00};
    exp_fetch = exp_tail;
  endtask

  task automatic top_up();
    while (exp_q.size() < 8) begin
      exp_q.push_back(exp_tail);
      exp_tail = exp_tail + 32'd4;
    end
  endtask

  // One cycle of stimulus, applied just after the rising edge.
  task automatic step(input bit rdr, input logic [31:0] t);
    @(posedge clk);
    #1;
    PCSrc    = rdr;
    PCTarget = t;
    if (rdr) restart_stream(t);
    top_up();
  endtask

  // imem: answers accepted requests in order, each no earlier than its own latency.
  always @(posedge clk) begin
    cyc++;
    #1;
    imem_rsp_valid = 1'b0;
    imem_rsp_data  = '0;
    if (rst && imem_q.size() > 0 && imem_q[0].due <= cyc) begin
      imem_rsp_valid = 1'b1;
      imem_rsp_data  = word_of(imem_q[0].addr);
      void'(imem_q.pop_front());
    end
  end

  // Monitor: sampled mid-cycle, when this cycle's handshakes are settled.
  int          m_out, m_due;
  logic [31:0] m_pc, m_w;
  always @(negedge clk) begin
    if (rst) begin
      m_out = imem_q.size() + (imem_rsp_valid ? 1 : 0);
      if (prev_redirect) chk("flush_after_redirect", 32'(instr_valid), 32'd0);
      if (PCSrc) chk("no_req_on_redirect", 32'(imem_req_valid), 32'd0);
      if (imem_req_valid && imem_req_ready) begin
        chk("req_addr", imem_req_addr, exp_fetch);
        chk("credit_bound", 32'(m_out < DEPTH), 32'd1);
        m_due = cyc + $urandom_range(lat_max, lat_min);
        if (m_due <= last_due) m_due = last_due + 1;
        last_due = m_due;
        imem_q.push_back('{addr: imem_req_addr, due: m_due});
        exp_fetch = exp_fetch + 32'd4;
      end
      if (instr_valid && instr_ready && !PCSrc) begin
        if (exp_q.size() == 0) begin
          checks++;
          $display("FAIL scoreboard_empty: got pc %h expected none", instr_pc);
        end else begin
          m_pc = exp_q.pop_front();
          m_w  = word_of(m_pc);
          chk("instr_pc", instr_pc, m_pc);
          chk("instr", instr, m_w);
          chk("fields", {15'd0, Op, funct3, funct7}, {15'd0, m_w[6:0], m_w[14:12], m_w[31:25]});
        end
      end
      prev_redirect = PCSrc;
    end else begin
      prev_redirect = 1'b0;
    end
  end

  int          first, n;
  bit          rdr;
  logic [31:0] tgt;
  initial begin
    rst = 1'b0; imem_req_ready = 1'b0; instr_ready = 1'b0;
    PCSrc = 1'b0; PCTarget = '0; imem_rsp_valid = 1'b0; imem_rsp_data = '0;
    restart_stream(32'h0);
    top_up();
    repeat (3) @(posedge clk);
    #1;
    chk("rst_req_valid", 32'(imem_req_valid), 32'd0);
    chk("rst_instr_valid", 32'(instr_valid), 32'd0);
    chk("rst_instr", instr, 32'd0);
    chk("rst_instr_pc", instr_pc, 32'd0);
    chk("rst_req_addr", imem_req_addr, 32'd0);

    // Boot with 1-cycle imem: first instruction visible in the third cycle, then one per cycle.
    imem_req_ready = 1'b1; instr_ready = 1'b1;
    @(posedge clk); #2; rst = 1'b1;
    first = 0;
    for (int i = 1; i <= 10; i++) begin
      @(negedge clk);
      if (instr_valid) begin first = i; break; end
    end
    chk("boot_latency", first, 32'd3);
    n = 0;
    repeat (20) begin
      step(1'b0, '0);
      @(negedge clk);
      if (instr_valid && instr_ready) n++;
    end
    chk("throughput", n, 32'd20);

    // Decode stall: fetch must stop with the buffer full and nothing in flight.
    step(1'b0, '0); instr_ready = 1'b0;
    repeat (9) step(1'b0, '0);
    @(negedge clk);
    chk("stall_req_valid", 32'(imem_req_valid), 32'd0);
    chk("stall_instr_valid", 32'(instr_valid), 32'd1);
    chk("stall_inflight", imem_q.size(), 32'd0);
    step(1'b0, '0); instr_ready = 1'b1;

    // Redirect with requests in flight, an unaligned target, wrap-around, back-to-back redirects.
    lat_min = 2; lat_max = 2;
    repeat (8) step(1'b0, '0);
    step(1'b1, 32'h100);
    repeat (12) step(1'b0, '0);
    lat_min = 1; lat_max = 1;
    repeat (6) step(1'b0, '0);
    step(1'b1, 32'h203);
    repeat (10) step(1'b0, '0);
    step(1'b1, 32'hFFFF_FFF8);
    repeat (10) step(1'b0, '0);
    step(1'b1, 32'h300);
    step(1'b1, 32'h400);
    repeat (10) step(1'b0, '0);

    // Random back-pressure, latency and redirects.
    lat_min = 1; lat_max = 3;
    repeat (1500) begin
      rdr = ($urandom_range(15) == 0);
      case ($urandom_range(3))
        0:       tgt = 32'h100;
        1:       tgt = 32'h203;
        2:       tgt = 32'hFFFF_FFF8;
        default: tgt = $urandom;
      endcase
      step(rdr, tgt);
      imem_req_ready = $urandom_range(1) == 1;
      instr_ready    = $urandom_range(3) != 0;
    end
    step(1'b0, '0);
    imem_req_ready = 1'b1; instr_ready = 1'b1; lat_min = 1; lat_max = 1;
    repeat (10) step(1'b0, '0);

    // Asynchronous reset mid-stream clears outputs without waiting for a clock.
    @(posedge clk); #3; rst = 1'b0; #1;
    chk("arst_req_valid", 32'(imem_req_valid), 32'd0);
    chk("arst_instr_valid", 32'(instr_valid), 32'd0);
    chk("arst_instr", instr, 32'd0);
    chk("arst_instr_pc", instr_pc, 32'd0);
    chk("arst_op", 32'(Op), 32'd0);
    imem_q.delete();
    imem_rsp_valid = 1'b0;
    PCSrc = 1'b0;
    restart_stream(32'h0);
    top_up();
    repeat (2) @(posedge clk);
    #2; rst = 1'b1;
    repeat (30) step(1'b0, '0);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
